mem_block_writer: RTL
=====================

Name: mem_block_writer

Overview:
- Write-combining initiator for data_memory's block write port (ptr_in / in_block / write_enable).
- Collects CPU word stores into one block buffer with a per-word valid mask.
- Partial blocks are completed by reading the current block through one data_memory read port (ptr_out / out_block), merging, then writing the full block back in one write cycle.
- Sits between the CPU store path and data_memory.

Parameters:
- WORD_SIZE, 32: bits per word; equals data_memory WORD_SIZE.
- BLOCK_SIZE, 4: words per block, power of 2 and >= 2; OFF = $clog2(BLOCK_SIZE).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  store request accepted when req_valid && req_ready.
- req_addr  in  WORD_SIZE  word address of the store.
- req_data  in  WORD_SIZE  store data.
- flush  in  1  level request to write the buffered block out.
- flush_done  out  1  one-cycle pulse when the flush completes.
- busy  out  1  high in any state other than IDLE.
- mem_ptr_out  out  WORD_SIZE  read pointer (block base) to data_memory.
- mem_out_block  in  WORD_SIZE*BLOCK_SIZE  block returned by data_memory for mem_ptr_out.
- mem_ptr_in  out  WORD_SIZE  write pointer (block base) to data_memory.
- mem_in_block  out  WORD_SIZE*BLOCK_SIZE  block write data.
- mem_write_enable  out  1  block write strobe, captured by data_memory on clk.

Behaviour:
- Reset is asynchronous on rst_n low. All of the following clear: state=IDLE, buf_valid, mask, buf_base, buffer words, pending register, mem_ptr_out, mem_ptr_in, mem_in_block, mem_write_enable, flush_done.
- During reset: req_ready=0. Once reset deasserts, req_ready=1 and busy=0.
- Reset mid-eviction aborts it. No write strobe is issued, and buffered data is discarded.
- Block base = req_addr with the low OFF bits cleared. Word index = req_addr[OFF-1:0].
- Word i occupies bits [i*WORD_SIZE +: WORD_SIZE] of every block bus.
- req_ready = (state==IDLE) && !flush. It never depends on req_valid.
- All mem_* outputs are registered.
- IDLE, accepted request:
  - Buffer empty: load base, write the word, set mask[i], set buf_valid.
  - Hit (same base): overwrite the word and set mask[i]. Repeated stores to the same word: last wins.
  - Miss: hold the request in the pending register and go to EVICT.
- IDLE, flush high:
  - buf_valid=1: go to EVICT.
  - buf_valid=0: pulse flush_done on the next cycle, with no memory traffic.
- EVICT (1 cycle):
  - mask all ones: go to WRITE; no read is issued.
  - otherwise: drive mem_ptr_out=buf_base and go to READ.
- READ (1 cycle): at the end of the cycle, register mem_out_block into the merge register and go to WRITE.
- WRITE (1 cycle):
  - Drive mem_write_enable=1, mem_ptr_in=buf_base.
  - mem_in_block word i = buffer word i if mask[i], else merge-register word i.
  - Next cycle: mem_write_enable=0; clear mask and buf_valid.
  - If a pending request exists, load it as a fresh buffer. Otherwise pulse flush_done.
  - Return to IDLE.
- Latency:
  - Miss with partial mask: 3 cycles of busy (EVICT, READ, WRITE).
  - Full mask: 2 cycles of busy (EVICT, WRITE).
- mem_write_enable is never high for 2 consecutive cycles.
- mem_ptr_in, mem_ptr_out and mem_in_block hold their last values outside WRITE and READ.

Optional Feature:
- Macro: MEM_BLOCK_WRITER_AUTOFLUSH_EN.
- Defined: when an accepted store completes the mask (all ones), the block goes to EVICT on the next cycle without waiting for flush or a miss. flush_done does not pulse for auto-flushes.
- Undefined: a full block stays buffered until a miss or flush.

Test Plan:
- Store 0xA0..0xA3 to addresses 8..11, then flush → exactly one write: mem_ptr_in=8, mem_in_block={A3,A2,A1,A0}. No READ state; flush_done 2 cycles after flush is sampled.
- Memory block 4 preloaded {44,33,22,11}; store 0xBB to addr 5, then flush → mem_ptr_out=4 during READ. Write of {44,33,BB,11} to ptr 4.
- Store addr 0 = 1, then store addr 16 = 2 (miss) → block 0 merged and written. Buffer then holds base 16 with mask=0001; req_ready low for 3 cycles.
- Store addr 3 = 5, then addr 3 = 6, then flush → written word 3 = 6.
- Flush with an empty buffer → flush_done the next cycle, mem_write_enable stays 0.
- Assert rst_n=0 during READ → no write strobe. All outputs are 0 and buf_valid=0; after release, req_ready=1.

Source files
------------

// File: rtl/mem_block_writer_if.sv
// Store-request, flush and data_memory block-port bundle for mem_block_writer.
// master = CPU/memory side, slave = the write-combining block itself.
interface mem_block_writer_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4
);
  logic                            req_valid;
  logic                            req_ready;
  logic [WORD_SIZE-1:0]            req_addr;
  logic [WORD_SIZE-1:0]            req_data;
  logic                            flush;
  logic                            flush_done;
  logic                            busy;
  logic [WORD_SIZE-1:0]            mem_ptr_out;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_out_block;
  logic [WORD_SIZE-1:0]            mem_ptr_in;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_in_block;
  logic                            mem_write_enable;

  modport master (
    output req_valid, req_addr, req_data, flush, mem_out_block,
    input  req_ready, flush_done, busy, mem_ptr_out, mem_ptr_in,
           mem_in_block, mem_write_enable
  );

  modport slave (
    input  req_valid, req_addr, req_data, flush, mem_out_block,
    output req_ready, flush_done, busy, mem_ptr_out, mem_ptr_in,
           mem_in_block, mem_write_enable
  );
endinterface

// File: rtl/mem_block_writer.sv
// Write-combining initiator for data_memory's block write port.
// Optional MEM_BLOCK_WRITER_AUTOFLUSH_EN evicts a block as soon as its mask fills.
module mem_block_writer_lane #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 keep_buf,
  input  logic [WORD_SIZE-1:0] buf_word,
  input  logic [WORD_SIZE-1:0] mem_word,
  output logic [WORD_SIZE-1:0] out_word
);
  assign out_word = keep_buf ? buf_word : mem_word;
endmodule

module mem_block_writer #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_block_writer_if.slave   bus
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam logic [WORD_SIZE-1:0] BASE_MASK = ~(WORD_SIZE'(BLOCK_SIZE - 1));

  typedef enum logic [1:0] {IDLE, EVICT, READ, WRITE} state_e;
  typedef logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] blk_t;
  typedef struct packed {
    logic                 vld;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } pend_t;

  state_e                state_q, state_d;
  blk_t                  buf_q, buf_d;
  logic [BLOCK_SIZE-1:0] mask_q, mask_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [WORD_SIZE-1:0]  buf_base_q, buf_base_d;
  pend_t                 pend_q, pend_d;
  logic [WORD_SIZE-1:0]  ptr_out_q, ptr_out_d;
  logic [WORD_SIZE-1:0]  ptr_in_q, ptr_in_d;
  blk_t                  in_block_q, in_block_d;
  logic                  we_q, we_d;
  logic                  flush_done_q, flush_done_d;
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
  logic                  auto_q, auto_d;
`endif

  blk_t                  mem_rd;
  blk_t                  merged;
  logic [OFF-1:0]        req_idx;
  logic [WORD_SIZE-1:0]  req_base;

  assign mem_rd   = bus.mem_out_block;
  assign req_idx  = bus.req_addr[OFF-1:0];
  assign req_base = bus.req_addr & BASE_MASK;

  // Merge sources: with a full mask the memory side is never selected,
  // so the same lanes serve both the EVICT->WRITE and READ->WRITE paths.
  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    mem_block_writer_lane #(.WORD_SIZE(WORD_SIZE)) u_lane (
      .keep_buf (mask_q[i]),
      .buf_word (buf_q[i]),
      .mem_word (mem_rd[i]),
      .out_word (merged[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    mask_d       = mask_q;
    buf_valid_d  = buf_valid_q;
    buf_base_d   = buf_base_q;
    pend_d       = pend_q;
    ptr_out_d    = ptr_out_q;
    ptr_in_d     = ptr_in_q;
    in_block_d   = in_block_q;
    we_d         = 1'b0;
    flush_done_d = 1'b0;
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
    auto_d       = auto_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          if (buf_valid_q) state_d = EVICT;
          else             flush_done_d = 1'b1;
        end else if (bus.req_valid) begin
          if (!buf_valid_q || req_base == buf_base_q) begin
            if (!buf_valid_q) buf_base_d = req_base;
            buf_d[req_idx]  = bus.req_data;
            mask_d[req_idx] = 1'b1;
            buf_valid_d     = 1'b1;
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
            if (&mask_d) begin
              state_d = EVICT;
              auto_d  = 1'b1;
            end
`endif
          end else begin
            pend_d  = '{vld: 1'b1, addr: bus.req_addr, data: bus.req_data};
            state_d = EVICT;
          end
        end
      end
      EVICT: begin
        if (&mask_q) begin
          state_d    = WRITE;
          we_d       = 1'b1;
          ptr_in_d   = buf_base_q;
          in_block_d = merged;
        end else begin
          ptr_out_d = buf_base_q;
          state_d   = READ;
        end
      end
      READ: begin
        state_d    = WRITE;
        we_d       = 1'b1;
        ptr_in_d   = buf_base_q;
        in_block_d = merged;
      end
      WRITE: begin
        state_d     = IDLE;
        mask_d      = '0;
        buf_valid_d = 1'b0;
        if (pend_q.vld) begin
          buf_base_d                  = pend_q.addr & BASE_MASK;
          buf_d[pend_q.addr[OFF-1:0]]  = pend_q.data;
          mask_d[pend_q.addr[OFF-1:0]] = 1'b1;
          buf_valid_d                 = 1'b1;
          pend_d.vld                  = 1'b0;
        end else begin
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
          flush_done_d = !auto_q;
`else
          flush_done_d = 1'b1;
`endif
        end
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
        auto_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      mask_q       <= '0;
      buf_valid_q  <= 1'b0;
      buf_base_q   <= '0;
      pend_q       <= '0;
      ptr_out_q    <= '0;
      ptr_in_q     <= '0;
      in_block_q   <= '0;
      we_q         <= 1'b0;
      flush_done_q <= 1'b0;
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
      auto_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      mask_q       <= mask_d;
      buf_valid_q  <= buf_valid_d;
      buf_base_q   <= buf_base_d;
      pend_q       <= pend_d;
      ptr_out_q    <= ptr_out_d;
      ptr_in_q     <= ptr_in_d;
      in_block_q   <= in_block_d;
      we_q         <= we_d;
      flush_done_q <= flush_done_d;
`ifdef MEM_BLOCK_WRITER_AUTOFLUSH_EN
      auto_q       <= auto_d;
`endif
    end
  end

  // Gating with rst_n keeps stores blocked while reset is held.
  assign bus.req_ready        = rst_n && (state_q == IDLE) && !bus.flush;
  assign bus.busy             = (state_q != IDLE);
  assign bus.flush_done       = flush_done_q;
  assign bus.mem_ptr_out      = ptr_out_q;
  assign bus.mem_ptr_in       = ptr_in_q;
  assign bus.mem_in_block     = in_block_q;
  assign bus.mem_write_enable = we_q;
endmodule
